// File: rtl/oto_pilot_pkg.sv
// ============================================================================
// Module : oto_pilot_pkg
// Brief  : Shared types and default sizes for the oto_pilot output arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package oto_pilot_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_CMD_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/oto_pilot_out_arbiter_if.sv
// ============================================================================
// Module : oto_pilot_out_arbiter_if
// Brief  : Requester-side and pad-side signal bundle of the output arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface oto_pilot_out_arbiter_if
  import oto_pilot_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CMD_W   = DEF_CMD_W
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CMD_W-1:0] cmd;
  logic [NUM_REQ-1:0]       cmd_valid;
  logic                     clr_err;
  logic [NUM_REQ-1:0]       grant;
  logic [CMD_W-1:0]         io_out;
  logic [CMD_W-1:0]         io_oeb;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output req, cmd, cmd_valid, clr_err,
    input  grant, io_out, io_oeb, busy, timeout_err
  );

  modport slave (
    input  req, cmd, cmd_valid, clr_err,
    output grant, io_out, io_oeb, busy, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/oto_pilot_rr_pick.sv
// ============================================================================
// Module : oto_pilot_rr_pick
// Brief  : Combinational round-robin pick among sources 1..NUM_REQ-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oto_pilot_rr_pick
  import oto_pilot_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:1] req_rr,
  input  wire logic [IDX_W-1:0]   ptr,
  output logic                    vld,
  output logic [IDX_W-1:0]        idx
);

  int cand;

  // Walk from the farthest candidate back to the nearest so the source just
  // after the pointer overwrites any later one.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      cand = int'(ptr) + k;
      if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
      if (req_rr[cand[IDX_W-1:0]]) begin
        vld = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/oto_pilot_out_arbiter.sv
// ============================================================================
// Module : oto_pilot_out_arbiter
// Brief  : Shares the actuator pads among requesters; source 0 is failsafe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oto_pilot_out_arbiter
  import oto_pilot_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int CMD_W       = DEF_CMD_W,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input wire logic           clk,
  input wire logic           rst_n,
  oto_pilot_out_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
  localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NUM_REQ - 1);

  state_e              state_q,  state_d;
  logic [IDX_W-1:0]    owner_q,  owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant_q,  grant_d;
  logic [CMD_W-1:0]    io_out_q, io_out_d;
  logic [CMD_W-1:0]    io_oeb_q, io_oeb_d;
  logic                busy_q,   busy_d;
  logic                err_q,    err_d;
  logic [HOLD_W-1:0]   hold_q,   hold_d;
  logic [WD_W-1:0]     wd_q,     wd_d;

  logic                rr_vld;
  logic [IDX_W-1:0]    rr_idx;
  logic [IDX_W-1:0]    win_idx;
  logic                any_req;
  logic [CMD_W-1:0]    cmd_win;
  logic [CMD_W-1:0]    cmd_own;
  logic                preempt;
  logic                release_own;

  oto_pilot_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_rr (bus.req[NUM_REQ-1:1]),
    .ptr    (rr_ptr_q),
    .vld    (rr_vld),
    .idx    (rr_idx)
  );

  assign any_req     = bus.req[0] | rr_vld;
  assign win_idx     = bus.req[0] ? '0 : rr_idx;
  assign cmd_win     = bus.cmd[int'(win_idx)*CMD_W +: CMD_W];
  assign cmd_own     = bus.cmd[int'(owner_q)*CMD_W +: CMD_W];
  assign preempt     = bus.req[0] && (owner_q != '0);
  assign release_own = (hold_q == '0) && !bus.req[owner_q];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    io_out_d = io_out_q;
    io_oeb_d = io_oeb_q;
    busy_d   = busy_q;
    err_d    = err_q;
    hold_d   = hold_q;
    wd_d     = wd_q;

    if (bus.clr_err) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d          = OWN;
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          io_out_d         = cmd_win;
          io_oeb_d         = '0;
          busy_d           = 1'b1;
          hold_d           = HOLD_LOAD;
          wd_d             = WD_LOAD;
          if (win_idx != '0) rr_ptr_d = win_idx;
        end
      end
      OWN: begin
        // Exit priority: failsafe preempt, then voluntary release, then watchdog.
        if (preempt || release_own || (wd_q == '0)) begin
          state_d  = DRAIN;
          grant_d  = '0;
          io_oeb_d = '1;
          if (!preempt && !release_own) err_d = 1'b1;
        end else begin
          if (bus.cmd_valid[owner_q]) begin
            io_out_d = cmd_own;
            wd_d     = WD_LOAD;
          end else begin
            wd_d = wd_q - 1'b1;
          end
          hold_d = (hold_q == '0) ? '0 : hold_q - 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        io_oeb_d = '1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PTR_RST;
      grant_q  <= '0;
      io_out_q <= '0;
      io_oeb_q <= '1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.io_out      = io_out_q;
  assign bus.io_oeb      = io_oeb_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_oto_pilot_out_arbiter.sv
// ============================================================================
// Module : tb_oto_pilot_out_arbiter
// Brief  : Directed scenarios plus randomized traffic against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oto_pilot_out_arbiter;

  localparam int NR   = 3;
  localparam int CW   = 3;
  localparam int HOLD = 16;
  localparam int TO   = 1024;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  oto_pilot_out_arbiter_if #(.NUM_REQ(NR), .CMD_W(CW)) bus ();

  oto_pilot_out_arbiter #(
    .NUM_REQ     (NR),
    .CMD_W       (CW),
    .HOLD_CYC    (HOLD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), drain flag, last RR winner.
  int          m_owner;
  int          m_last;
  bit          m_drain;
  bit          m_err;
  logic [CW-1:0] m_out;
  int          m_hold;
  int          m_wd;

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_drain = 1'b0;
    m_err   = 1'b0;
    m_out   = '0;
    m_hold  = 0;
    m_wd    = 0;
  endtask

  task automatic model_step(input logic [NR-1:0] r, input logic [NR*CW-1:0] c,
                            input logic [NR-1:0] v, input bit clr);
    bit to_hit;
    bit pre;
    bit rel;
    int w;
    int s;
    to_hit = 1'b0;
    if (m_drain) begin
      m_drain = 1'b0;
    end else if (m_owner < 0) begin
      if (r != '0) begin
        w = -1;
        if (r[0]) w = 0;
        else begin
          for (int j = 1; j < NR; j++) begin
            s = ((m_last - 1 + j) % (NR - 1)) + 1;
            if (w < 0 && r[s]) w = s;
          end
        end
        m_owner = w;
        m_out   = c[w*CW +: CW];
        m_hold  = HOLD;
        m_wd    = TO;
        if (w != 0) m_last = w;
      end
    end else begin
      pre = r[0] && (m_owner != 0);
      rel = (m_hold == 0) && !r[m_owner];
      if (pre || rel || m_wd == 0) begin
        to_hit  = !pre && !rel;
        m_owner = -1;
        m_drain = 1'b1;
      end else begin
        if (v[m_owner]) begin
          m_out = c[m_owner*CW +: CW];
          m_wd  = TO;
        end else begin
          m_wd = m_wd - 1;
        end
        if (m_hold > 0) m_hold = m_hold - 1;
      end
    end
    if (clr) m_err = 1'b0;
    if (to_hit) m_err = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.req       = '0;
    bus.cmd       = '0;
    bus.cmd_valid = '0;
    bus.clr_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    idle_inputs();
    #1;
    n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b expected 000", bus.grant); end
    n_tests++; if (bus.io_out !== 3'b000) begin n_fail++; $display("FAIL reset_io_out: got %b expected 000", bus.io_out); end
    n_tests++; if (bus.io_oeb !== 3'b111) begin n_fail++; $display("FAIL reset_io_oeb: got %b expected 111", bus.io_oeb); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    do_reset();
    bus.cmd[5:3] = 3'b101;
    bus.req      = 3'b010;
    @(negedge clk);
    n_tests++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL single_grant: got %b expected 010", bus.grant); end
    n_tests++; if (bus.io_out !== 3'b101) begin n_fail++; $display("FAIL single_io_out: got %b expected 101", bus.io_out); end
    n_tests++; if (bus.io_oeb !== 3'b000) begin n_fail++; $display("FAIL single_io_oeb: got %b expected 000", bus.io_oeb); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
  endtask

  task automatic test_rr_alternate();
    int seq[3];
    logic [NR-1:0] exp_g;
    seq = '{1, 2, 1};
    do_reset();
    bus.req = 3'b110;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      exp_g = '0;
      exp_g[seq[n]] = 1'b1;
      n_tests++; if (bus.grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, bus.grant, exp_g); end
      repeat (19) @(negedge clk);
      bus.req[seq[n]] = 1'b0;
      @(negedge clk);
      n_tests++; if ({bus.grant, bus.io_oeb, bus.busy} !== 7'b000_111_1) begin
        n_fail++; $display("FAIL rr_drain[%0d]: got grant=%b oeb=%b busy=%b expected 000/111/1", n, bus.grant, bus.io_oeb, bus.busy);
      end
      bus.req[seq[n]] = 1'b1;
      @(negedge clk);
      n_tests++; if ({bus.grant, bus.busy} !== 4'b000_0) begin
        n_fail++; $display("FAIL rr_idle[%0d]: got grant=%b busy=%b expected 000/0", n, bus.grant, bus.busy);
      end
      @(negedge clk);
    end
    bus.req = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_preempt();
    do_reset();
    bus.cmd = {3'b110, 3'b000, 3'b011};
    bus.req = 3'b100;
    @(negedge clk);
    n_tests++; if ({bus.grant, bus.io_out} !== 6'b100_110) begin
      n_fail++; $display("FAIL preempt_owner2: got grant=%b out=%b expected 100/110", bus.grant, bus.io_out);
    end
    repeat (6) @(negedge clk);
    bus.req[0]        = 1'b1;
    bus.cmd[8:6]      = 3'b001;
    bus.cmd_valid     = 3'b100;
    @(negedge clk);
    bus.cmd_valid = '0;
    n_tests++; if ({bus.grant, bus.io_oeb, bus.io_out, bus.busy} !== 10'b000_111_110_1) begin
      n_fail++; $display("FAIL preempt_drain: got grant=%b oeb=%b out=%b busy=%b expected 000/111/110/1",
                         bus.grant, bus.io_oeb, bus.io_out, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if ({bus.grant, bus.io_out} !== 6'b001_011) begin
      n_fail++; $display("FAIL preempt_failsafe: got grant=%b out=%b expected 001/011", bus.grant, bus.io_out);
    end
    repeat (30) @(negedge clk);
    n_tests++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL failsafe_kept: got %b expected 001", bus.grant); end
    bus.req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hold_min();
    do_reset();
    bus.req = 3'b010;
    @(negedge clk);
    repeat (3) @(negedge clk);
    bus.req = '0;
    repeat (13) @(negedge clk);
    n_tests++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL hold_kept: got %b expected 010", bus.grant); end
    @(negedge clk);
    n_tests++; if ({bus.grant, bus.io_oeb} !== 6'b000_111) begin
      n_fail++; $display("FAIL hold_release: got grant=%b oeb=%b expected 000/111", bus.grant, bus.io_oeb);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout(input bit drop_at_zero);
    do_reset();
    bus.req = 3'b010;
    @(negedge clk);
    repeat (TO) @(negedge clk);
    n_tests++; if ({bus.grant, bus.timeout_err} !== 4'b010_0) begin
      n_fail++; $display("FAIL wd_edge[%0d]: got grant=%b err=%b expected 010/0", drop_at_zero, bus.grant, bus.timeout_err);
    end
    if (drop_at_zero) begin
      bus.req = '0;
      @(negedge clk);
      n_tests++; if ({bus.grant, bus.timeout_err} !== 4'b000_0) begin
        n_fail++; $display("FAIL release_beats_timeout: got grant=%b err=%b expected 000/0", bus.grant, bus.timeout_err);
      end
    end else begin
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      bus.req     = '0;
      n_tests++; if ({bus.grant, bus.io_oeb, bus.timeout_err} !== 7'b000_111_1) begin
        n_fail++; $display("FAIL timeout_revoke: got grant=%b oeb=%b err=%b expected 000/111/1", bus.grant, bus.io_oeb, bus.timeout_err);
      end
      repeat (3) @(negedge clk);
      n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.timeout_err); end
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", bus.timeout_err); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    bus.cmd[5:3] = 3'b111;
    bus.req      = 3'b010;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.grant, bus.io_oeb, bus.io_out, bus.busy} !== 10'b000_111_000_0) begin
      n_fail++; $display("FAIL async_reset: got grant=%b oeb=%b out=%b busy=%b expected 000/111/000/0",
                         bus.grant, bus.io_oeb, bus.io_out, bus.busy);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int cycles);
    logic [NR-1:0] eg;
    logic [CW-1:0] eo;
    logic [3*NR-1+2:0] exp_v, got_v;
    do_reset();
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      if (!bus.req[0]) bus.req[0] = ($urandom_range(0, 79) == 0);
      else             bus.req[0] = ($urandom_range(0, 5) != 0);
      for (int k = 1; k < NR; k++)
        if ($urandom_range(0, 19) == 0) bus.req[k] = ~bus.req[k];
      bus.cmd = NR*CW'($urandom);
      for (int k = 0; k < NR; k++) bus.cmd_valid[k] = ($urandom_range(0, 3) == 0);
      bus.clr_err = ($urandom_range(0, 39) == 0);
      model_step(bus.req, bus.cmd, bus.cmd_valid, bus.clr_err);
      @(negedge clk);
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      eo = (m_owner >= 0) ? '0 : '1;
      exp_v = {eg, m_out, eo, (m_owner >= 0) || m_drain, m_err};
      got_v = {bus.grant, bus.io_out, bus.io_oeb, bus.busy, bus.timeout_err};
      n_tests++; if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random[%0d]: got grant/out/oeb/busy/err=%b expected %b", i, got_v, exp_v);
      end
    end
    idle_inputs();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    idle_inputs();
    test_reset();
    test_single_grant();
    test_rr_alternate();
    test_preempt();
    test_hold_min();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_reset_mid_own();
    test_random(4000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
